byte_joining_ctrl: RTL

- Sequencer for the 4-lane byte-joining datapath.
- On each lane-group-ready event from the serial-to-parallel stage it does three things:
  - Strobes the lane capture registers.
  - Steps the 2-bit lane select `ctr_3` across the active lanes.
  - Flags each valid output byte.
- Runs on the fast byte clock, 4x the lane clock. Supports 1-, 2- or 4-lane configurations and back-to-back groups without bubbles.

---
 rtl/byte_joining_ctrl_if.sv | 25 ++
 rtl/byte_joining_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/byte_joining_ctrl_if.sv
// Control bundle between the byte-joining sequencer and its surroundings.
// master drives the group request and config; slave (the sequencer) drives the strobes and status.
interface byte_joining_ctrl_if #(
   parameter int SEL_W = 2
);
   logic             enable;
   logic [1:0]       lane_cfg;
   logic             in_valid;
   logic             load;
   logic [SEL_W-1:0] ctr_3;
   logic             out_valid;
   logic             sop;
   logic             busy;
   logic             err_overrun;

   modport master (
      output enable, lane_cfg, in_valid,
      input  load, ctr_3, out_valid, sop, busy, err_overrun
   );

   modport slave (
      input  enable, lane_cfg, in_valid,
      output load, ctr_3, out_valid, sop, busy, err_overrun
   );
endinterface

// File: rtl/byte_joining_ctrl.sv
// Lane-join sequencer: strobes lane capture, walks the lane select and flags each output byte.
// in_valid -> load 1 cycle later -> first byte 2 cycles later; chained groups run gap-free, no backpressure.
module byte_joining_ctrl #(
   parameter int SEL_W = 2
) (
   input  logic               clk1M,
   input  logic               reset,
   byte_joining_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ctr_q, ctr_d;
   logic             load_q, load_d;
   logic             out_valid_q, out_valid_d;
   logic             sop_q, sop_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             pend_q, pend_d;
   logic [1:0]       cfg_q, cfg_d;
   logic [1:0]       cfg_nxt_q, cfg_nxt_d;
   logic             accept;

   function automatic logic [SEL_W-1:0] last_lane(input logic [1:0] cfg);
      case (cfg)
         2'b00:   last_lane = '0;
         2'b01:   last_lane = SEL_W'(1);
         default: last_lane = '1;
      endcase
   endfunction

   assign accept = bus.in_valid && bus.enable;

   always_comb begin
      state_d   = state_q;
      ctr_d     = '0;
      load_d    = 1'b0;
      err_d     = err_q;
      pend_d    = pend_q;
      cfg_d     = cfg_q;
      cfg_nxt_d = cfg_nxt_q;

      // A group in flight queues one request; a second one is an overrun.
      if (state_q != IDLE) begin
         if (!bus.enable) begin
            pend_d = 1'b0;
         end else if (bus.in_valid) begin
            if (pend_q) begin
               err_d = 1'b1;
            end else begin
               pend_d = 1'b1;
            end
         end
      end

      case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            if (accept) begin
               state_d = LOAD;
               cfg_d   = bus.lane_cfg;
            end
         end
         LOAD: begin
            state_d = SEND;
         end
         SEND: begin
            if (ctr_q == last_lane(cfg_q)) begin
               if (load_q) begin
                  cfg_d = cfg_nxt_q;
               end else if (accept) begin
                  state_d = LOAD;
                  cfg_d   = bus.lane_cfg;
                  pend_d  = 1'b0;
               end else begin
                  state_d = IDLE;
                  pend_d  = 1'b0;
               end
            end else begin
               ctr_d = ctr_q + SEL_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // load is registered, so the chain decision is taken one edge before the last byte.
      if (state_d == SEND && ctr_d == last_lane(cfg_d) && bus.enable && (pend_q || bus.in_valid)) begin
         load_d    = 1'b1;
         cfg_nxt_d = bus.lane_cfg;
         pend_d    = 1'b0;
      end
      if (state_d == LOAD) begin
         load_d = 1'b1;
      end

      out_valid_d = (state_d == SEND);
      sop_d       = (state_d == SEND) && (ctr_d == '0);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk1M) begin
      if (reset) begin
         state_q     <= IDLE;
         ctr_q       <= '0;
         load_q      <= 1'b0;
         out_valid_q <= 1'b0;
         sop_q       <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
         cfg_q       <= 2'b00;
         cfg_nxt_q   <= 2'b00;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         load_q      <= load_d;
         out_valid_q <= out_valid_d;
         sop_q       <= sop_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
         cfg_q       <= cfg_d;
         cfg_nxt_q   <= cfg_nxt_d;
      end
   end

   assign bus.load        = load_q;
   assign bus.ctr_3       = ctr_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.sop         = sop_q;
   assign bus.busy        = busy_q;
   assign bus.err_overrun = err_q;

endmodule
